// File: rtl/mdu_if.sv
// mdu_if: E/D-stage request and HI/LO result bundle between pipeline and MDU controller.
// Signals:
//   start   - E-stage MDU instruction valid this cycle
//   mdu_op  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu
//   rs_val  - first operand / mthi-mtlo data
//   rt_val  - second operand
//   md_in_d - D-stage instruction uses the MDU
//   busy    - multi-cycle operation in progress
//   stall   - pipeline stall request
//   hi, lo  - HI/LO registers
// Modports: master (pipeline side), slave (MDU side).
interface mdu_if;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_in_d;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdu_op, rs_val, rt_val, md_in_d,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, mdu_op, rs_val, rt_val, md_in_d,
        output busy, stall, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller owning the HI/LO registers.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - mdu_if.slave: start/mdu_op/rs_val/rt_val/md_in_d in, busy/stall/hi/lo out
// Build option: define MDU_MADD_EN to enable madd/maddu (ops 7/8); otherwise they are no-ops.
module mdu_ctrl (
    input logic  clk,
    input logic  reset,
    mdu_if.slave bus
);
`ifdef MDU_MADD_EN
    localparam logic MADD_EN = 1'b1;
`else
    localparam logic MADD_EN = 1'b0;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        start_mc;
    logic        is_sgn;
    logic [63:0] prod;
    logic [63:0] acc;
    logic [31:0] quo;
    logic [31:0] rem;

    function automatic logic mul_op(input logic [3:0] op);
        return op == 4'd1 || op == 4'd2 || (MADD_EN && (op == 4'd7 || op == 4'd8));
    endfunction

    function automatic logic div_op(input logic [3:0] op);
        return op == 4'd3 || op == 4'd4;
    endfunction

    assign start_mc = bus.start & (mul_op(bus.mdu_op) | div_op(bus.mdu_op));

    // Signed ops sign-extend both operands; the low 64 bits of that product are exact.
    assign is_sgn = op_q == 4'd1 || op_q == 4'd3 || op_q == 4'd7;
    assign prod   = (is_sgn ? {{32{a_q[31]}}, a_q} : {32'd0, a_q}) *
                    (is_sgn ? {{32{b_q[31]}}, b_q} : {32'd0, b_q});
    assign acc    = op_q >= 4'd7 ? {hi_q, lo_q} + prod : prod;
    assign quo    = is_sgn ? $unsigned($signed(a_q) / $signed(b_q)) : a_q / b_q;
    assign rem    = is_sgn ? $unsigned($signed(a_q) % $signed(b_q)) : a_q % b_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == IDLE) begin
            if (start_mc) begin
                state_d = RUN;
                cnt_d   = div_op(bus.mdu_op) ? 4'd10 : 4'd5;
                op_d    = bus.mdu_op;
                a_d     = bus.rs_val;
                b_d     = bus.rt_val;
            end else if (bus.start && bus.mdu_op == 4'd5) begin
                hi_d = bus.rs_val;
            end else if (bus.start && bus.mdu_op == 4'd6) begin
                lo_d = bus.rs_val;
            end
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = IDLE;
                if (mul_op(op_q)) begin
                    {hi_d, lo_d} = acc;
                end else if (b_q != 32'd0) begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy  = state_q == RUN;
    assign bus.stall = bus.md_in_d & (start_mc | bus.busy);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl (expected HI/LO and busy length queued at issue).
module tb_mdu_ctrl;
`ifdef MDU_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [63:0] m_hl = 64'd0;
    logic [63:0] exp_q[$];
    int          cyc_q[$];

    mdu_if bus ();

    mdu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [63:0] hl);
        longint sp;
        logic [63:0] up;
        int a, b;
        sp = longint'(signed'(rs)) * longint'(signed'(rt));
        up = {32'd0, rs} * {32'd0, rt};
        a = rs;
        b = rt;
        case (op)
            4'd1: return sp;
            4'd2: return up;
            4'd3: return rt == 0 ? hl : {32'(a % b), 32'(a / b)};
            4'd4: return rt == 0 ? hl : {rs % rt, rs / rt};
            4'd5: return {rs, hl[31:0]};
            4'd6: return {hl[63:32], rs};
            4'd7: return MADD ? hl + sp : hl;
            4'd8: return MADD ? hl + up : hl;
            default: return hl;
        endcase
    endfunction

    function automatic int cycles(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd2) return 5;
        if (op == 4'd3 || op == 4'd4) return 10;
        if (op == 4'd7 || op == 4'd8) return MADD ? 5 : 0;
        return 0;
    endfunction

    // Issue one op, then scramble operands, optionally poke an illegal mthi while busy.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input bit poke);
        int n;
        int c;
        m_hl = model(op, rs, rt, m_hl);
        exp_q.push_back(m_hl);
        cyc_q.push_back(cycles(op));
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mdu_op = op;
        bus.rs_val = rs;
        bus.rt_val = rt;
        #1 chk({tag, "_stall0"}, 64'(bus.stall), 64'(bus.md_in_d && cycles(op) != 0));
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.mdu_op = 4'd0;
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
        n = 0;
        while (bus.busy && n < 20) begin
            if (n == 0) chk({tag, "_stallb"}, 64'(bus.stall), 64'(bus.md_in_d));
            if (poke && n == 1) begin
                bus.start  = 1'b1;
                bus.mdu_op = 4'd5;
            end else begin
                bus.start  = 1'b0;
                bus.mdu_op = 4'd0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.start = 1'b0;
        c = cyc_q.pop_front();
        chk({tag, "_busy"}, 64'(n), 64'(c));
        chk({tag, "_hilo"}, {bus.hi, bus.lo}, exp_q.pop_front());
        chk({tag, "_stall1"}, 64'(bus.stall), 64'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] rs, rt;
        bus.start   = 1'b0;
        bus.mdu_op  = 4'd0;
        bus.rs_val  = 32'd0;
        bus.rt_val  = 32'd0;
        bus.md_in_d = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);

        bus.md_in_d = 1'b1;
        do_op("mult", 4'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        bus.md_in_d = 1'b0;
        do_op("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
        do_op("div", 4'd3, -32'sd7, 32'd2, 1'b0);
        do_op("divu0", 4'd4, 32'd7, 32'd0, 1'b0);
        do_op("mthi", 4'd5, 32'h12345678, 32'd0, 1'b0);
        do_op("mthi0", 4'd5, 32'd0, 32'd0, 1'b0);
        do_op("mtlo", 4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
        bus.md_in_d = 1'b1;
        do_op("madd", 4'd7, 32'd1, 32'd1, 1'b0);
        do_op("maddu", 4'd8, 32'hFFFFFFFF, 32'h3, 1'b0);
        do_op("nop0", 4'd0, 32'hDEADBEEF, 32'd5, 1'b0);
        do_op("nop9", 4'd9, 32'hDEADBEEF, 32'd5, 1'b0);
        do_op("poke", 4'd1, 32'h00012345, 32'hFFFF0001, 1'b1);
        bus.md_in_d = 1'b0;

        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 9));
            rs = $urandom;
            rt = (i % 5 == 0) ? 32'd0 : $urandom;
            if (rs == 32'h80000000) rs = 32'd1;
            bus.md_in_d = 1'($urandom_range(0, 1));
            do_op("rnd", op, rs, rt, 1'b0);
        end

        // Abort a divide with reset at its fourth busy cycle.
        bus.md_in_d = 1'b0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mdu_op = 4'd3;
        bus.rs_val = 32'd100;
        bus.rt_val = 32'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        m_hl = 64'd0;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_late_busy", 64'(bus.busy), 64'd0);
        chk("abort_late_hilo", {bus.hi, bus.lo}, 64'd0);
        do_op("post_rst", 4'd3, -32'sd100, 32'd7, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
